bounce_sprite: RTL
==================

BOUNCE_SPRITE -- requirements
Module: bounce_sprite

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- H_ACTIVE, 640, visible width in pixels
- V_ACTIVE, 480, visible height in lines
- SPRITE_W, 32, sprite width in pixels
- SPRITE_H, 32, sprite height in lines
- STEP, 2, pixels moved per frame per axis
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk, input, 1, system clock; the only clock
- rst_n, input, 1, asynchronous active-low reset
- clk_en, input, 1, pixel clock enable
- freeze, input, 1, when high, sprite position and direction hold
- active_in, input, 1, active region from the timing generator
- hsync_in, input, 1, hsync from the timing generator, active low
- vsync_in, input, 1, vsync from the timing generator, active low
- v_begin, input, 1, start-of-frame strobe, already qualified by clk_en
- hpos, input, 10, current pixel column
- vpos, input, 10, current line
- r, output, 2, red pixel value
- g, output, 2, green pixel value
- b, output, 2, blue pixel value
- hsync, output, 1, delayed hsync aligned to rgb, active low
- vsync, output, 1, delayed vsync aligned to rgb, active low
- bounce, output, 1, one-clk pulse when either axis reverses
REQ-003 The block SHALL use one clock, clk; reset rst_n SHALL be asynchronous and active-low.

Function
REQ-004 The block SHALL hold the sprite origin in x (10 bits) and y (10 bits), with x in [0, H_ACTIVE-SPRITE_W] and y in [0, V_ACTIVE-SPRITE_H].
REQ-005 The block SHALL hold one direction bit per axis (0 = increasing, 1 = decreasing).
REQ-006 On a clk cycle with v_begin=1 and freeze=0, each axis SHALL step by STEP in its current direction.
REQ-007 Step overshoot: if the step would pass a bound (below 0 or above the maximum), the coordinate SHALL clamp to that bound and the direction bit SHALL toggle in the same cycle.
REQ-008 Exact landing: landing exactly on a bound SHALL also toggle the direction bit.
REQ-009 Bounds SHALL be compared in at least 11-bit arithmetic so that a step below 0 is detected and not wrapped.
REQ-010 bounce SHALL pulse for exactly one clk cycle, the cycle after the update, when either axis toggles. A simultaneous corner hit SHALL give a single pulse.
REQ-011 A 3-bit colour index SHALL increment once per bounce event. It SHALL skip value 0 (sequence 1..7, then 1).
REQ-012 Hit test: hit = (x <= hpos < x+SPRITE_W) and (y <= vpos < y+SPRITE_H), computed without overflow.
REQ-013 Pipeline stage 1 SHALL register hit, active_in, hsync_in and vsync_in.
REQ-014 Pipeline stage 2 SHALL register rgb and the syncs. Both stages SHALL advance only when clk_en=1.
REQ-015 Latency from inputs to r/g/b/hsync/vsync SHALL be exactly 2 clk_en ticks.
REQ-016 Colour output SHALL be as follows:
- active and hit: rgb = colour index bits {r=idx[2]*3, g=idx[1]*3, b=idx[0]*3}
- active and not hit: rgb = 2'b01 on every channel (background)
- inactive: rgb = 0
REQ-017 Position and colour updates SHALL occur only at v_begin, so the sprite never tears mid-frame.
REQ-018 freeze SHALL NOT stall the pixel pipeline or the sync outputs.

Reset
REQ-019 rst_n low SHALL set the following reset values:
- x=0, y=0, both directions=0, colour index=1
- pipeline registers: syncs=1, hit=0, active=0
- r=g=b=0, hsync=1, vsync=1, bounce=0
REQ-020 Reset mid-frame SHALL take effect immediately. The next v_begin after release SHALL move the sprite from (0,0).

Structure
REQ-021 vga_pkg SHALL hold the H/V timing constants, the rgb2_t typedef (2-bit channel) and the colour_idx_t typedef (3 bits).
REQ-022 The per-axis step/clamp/toggle logic SHALL be one sub-module, bounce_axis (parameters MAX and STEP), instantiated twice.

Verification
REQ-023 Reset, then v_begin x1 -> x=2, y=2, bounce=0, colour index 1.
REQ-024 Set x=606 rising (max 608), STEP=2, then v_begin -> x=608, x direction=1, bounce pulses once, colour index 1->2.
REQ-025 x=1, y=1, both decreasing, then v_begin -> x=0, y=0, both directions=0, exactly one bounce pulse.
REQ-026 Colour wrap: index at 7, then bounce -> index 1, never 0.
REQ-027 Sprite at (100,50): hpos=100, vpos=50, active=1 -> rgb=colour two clk_en later; hpos=132 -> background; hsync_in low -> hsync low two clk_en later.
REQ-028 Apply freeze=1 across 3 frames -> x and y unchanged, syncs still propagate. Assert rst_n mid-line -> outputs match the REQ-019 values immediately.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared display constants, pixel/colour types and small colour helpers
// used by the bouncing-sprite overlay.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    typedef logic [1:0] rgb2_t;
    typedef logic [2:0] colour_idx_t;

    // Colour index cycles 1..7; zero is reserved so the sprite never goes black.
    function automatic colour_idx_t next_colour(input colour_idx_t c);
        return (c == 3'd7) ? 3'd1 : c + 3'd1;
    endfunction

    function automatic rgb2_t chan(input logic on);
        return on ? 2'b11 : 2'b00;
    endfunction

endpackage

// File: rtl/bounce_axis.sv
// One axis of sprite motion: steps by STEP per enabled cycle, clamps at
// 0 and MAX, and reverses direction on any contact with a bound.
module bounce_axis #(
    parameter int MAX  = 608,
    parameter int STEP = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step_en,
    output logic [9:0] pos,
    output logic       dir,
    output logic       flip
);

    localparam logic [10:0] MAX11  = 11'(MAX);
    localparam logic [10:0] STEP11 = 11'(STEP);

    logic [10:0] up_sum;
    logic [10:0] dn_diff;
    logic [9:0]  pos_next;

    // 11-bit math keeps an underflow visible in bit 10 instead of wrapping.
    always_comb begin
        up_sum   = {1'b0, pos} + STEP11;
        dn_diff  = {1'b0, pos} - STEP11;
        pos_next = pos;
        flip     = 1'b0;
        if (step_en) begin
            if (!dir) begin
                if (up_sum >= MAX11) begin
                    pos_next = MAX11[9:0];
                    flip     = 1'b1;
                end else begin
                    pos_next = up_sum[9:0];
                end
            end else begin
                if (dn_diff[10] || dn_diff == 11'd0) begin
                    pos_next = '0;
                    flip     = 1'b1;
                end else begin
                    pos_next = dn_diff[9:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos <= '0;
            dir <= 1'b0;
        end else begin
            pos <= pos_next;
            dir <= dir ^ flip;
        end
    end

endmodule

// File: rtl/bounce_sprite.sv
// Bouncing square sprite overlaid on the timing generator's active area,
// with a two-tick pixel pipeline keeping rgb and syncs aligned.
module bounce_sprite
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int SPRITE_W = 32,
    parameter int SPRITE_H = 32,
    parameter int STEP     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic       freeze,
    input  logic       active_in,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       v_begin,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    output rgb2_t      r,
    output rgb2_t      g,
    output rgb2_t      b,
    output logic       hsync,
    output logic       vsync,
    output logic       bounce
);

    logic [9:0]  x;
    logic [9:0]  y;
    logic        dir_x;
    logic        dir_y;
    logic        flip_x;
    logic        flip_y;
    logic        step_en;
    colour_idx_t colour_idx;
    logic        hit;
    logic        hit_q;
    logic        active_q;
    logic        hsync_q;
    logic        vsync_q;

    assign step_en = v_begin & ~freeze;

    bounce_axis #(.MAX(H_ACTIVE - SPRITE_W), .STEP(STEP)) u_axis_x (
        .clk(clk), .rst_n(rst_n), .step_en(step_en),
        .pos(x), .dir(dir_x), .flip(flip_x)
    );

    bounce_axis #(.MAX(V_ACTIVE - SPRITE_H), .STEP(STEP)) u_axis_y (
        .clk(clk), .rst_n(rst_n), .step_en(step_en),
        .pos(y), .dir(dir_y), .flip(flip_y)
    );

    // A corner hit flips both axes in one cycle but counts as one bounce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bounce     <= 1'b0;
            colour_idx <= 3'd1;
        end else begin
            bounce <= flip_x | flip_y;
            if (flip_x | flip_y)
                colour_idx <= next_colour(colour_idx);
        end
    end

    always_comb begin
        hit = ({1'b0, hpos} >= {1'b0, x}) && ({1'b0, hpos} < {1'b0, x} + 11'(SPRITE_W)) &&
              ({1'b0, vpos} >= {1'b0, y}) && ({1'b0, vpos} < {1'b0, y} + 11'(SPRITE_H));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q    <= 1'b0;
            active_q <= 1'b0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            r        <= '0;
            g        <= '0;
            b        <= '0;
            hsync    <= 1'b1;
            vsync    <= 1'b1;
        end else if (clk_en) begin
            hit_q    <= hit;
            active_q <= active_in;
            hsync_q  <= hsync_in;
            vsync_q  <= vsync_in;
            hsync    <= hsync_q;
            vsync    <= vsync_q;
            if (!active_q) begin
                r <= '0;
                g <= '0;
                b <= '0;
            end else if (hit_q) begin
                r <= chan(colour_idx[2]);
                g <= chan(colour_idx[1]);
                b <= chan(colour_idx[0]);
            end else begin
                r <= 2'b01;
                g <= 2'b01;
                b <= 2'b01;
            end
        end
    end

endmodule
